// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with synchronous clamped load, combinational
// terminal-count flag and a registered one-cycle wrap pulse.
module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    generate
        if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
            $error("updown_mod_counter: WIDTH/MODULUS out of legal range");
        end
    endgenerate

    // MODULUS may equal 2^WIDTH, so the load clamp compares one bit wider.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            tc = up ? (count_q == MAX_VAL) : (count_q == '0);
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = tc;
        if (load) begin
            count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
        end else if (en) begin
            if (up) begin
                count_d = (count_q == MAX_VAL) ? '0 : count_q + ONE;
            end else begin
                count_d = (count_q == '0) ? MAX_VAL : count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: driver queues expected q/wrap/tc per cycle, a negedge
// monitor pops and compares. Instance A: WIDTH=4 MODULUS=10; B: WIDTH=2 MODULUS=2.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] qa;
    logic [1:0] qb;
    logic       tca, wrapa, tcb, wrapb;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(qa), .tc(tca), .wrap(wrapa)
    );

    updown_mod_counter #(.WIDTH(2), .MODULUS(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[1:0]), .q(qb), .tc(tcb), .wrap(wrapb)
    );

    typedef struct {
        int       cyc;
        bit       sel;
        logic [3:0] eq;
        logic     ew;
        logic     etc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything expected for this cycle is compared at the negedge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            exp_t e;
            logic [3:0] gq;
            logic gw, gt;
            e  = sbq.pop_front();
            gq = e.sel ? {2'b00, qb} : qa;
            gw = e.sel ? wrapb : wrapa;
            gt = e.sel ? tcb : tca;
            chk_cnt++;
            if (gq === e.eq && gw === e.ew && gt === e.etc) begin
                pass_cnt++;
            end else begin
                $display("FAIL dut_%s cyc=%0d: got q=%0d wrap=%b tc=%b, expected q=%0d wrap=%b tc=%b",
                         e.sel ? "b" : "a", cyc, gq, gw, gt, e.eq, e.ew, e.etc);
            end
        end
    end

    task automatic drive(input bit r, ld, input int lv, input bit e, u);
        @(posedge clk);
        #1;
        reset = r; load = ld; load_val = 4'(lv); en = e; up = u;
    endtask

    // Apply inputs for one cycle; expected values describe this cycle (before its edge).
    task automatic vec(input bit sel, r, ld, input int lv, input bit e, u,
                       input int eq, input bit ew, etc);
        exp_t x;
        drive(r, ld, lv, e, u);
        x.cyc = cyc; x.sel = sel; x.eq = 4'(eq); x.ew = ew; x.etc = etc;
        sbq.push_back(x);
    endtask

    function automatic int mdl_next(int qv, int m, bit r, ld, int lv, bit e, u);
        if (r)  return 0;
        if (ld) return (lv < m) ? lv : m - 1;
        if (e)  return u ? ((qv == m - 1) ? 0 : qv + 1) : ((qv == 0) ? m - 1 : qv - 1);
        return qv;
    endfunction

    function automatic bit mdl_tc(int qv, int m, bit ld, bit e, u);
        return e && !ld && (u ? (qv == m - 1) : (qv == 0));
    endfunction

    initial begin
        int  ma, mb;
        bit  wa, wb;
        // Reset for two cycles; outputs before then are undefined.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Count up 12 edges: q 0..9,0,1 then 2; tc at 9, wrap after 9->0.
        for (int i = 0; i < 12; i++) vec(0, 0, 0, 0, 1, 1, i % 10, i == 10, i == 9);
        // Clamped load of 13 -> 9, then count down.
        vec(0, 0, 1, 13, 0, 0, 2, 0, 0);
        for (int v = 9; v >= 1; v--) vec(0, 0, 0, 0, 1, 0, v, 0, 0);
        vec(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // Down-wrap to 9: wrap pulse; load 5 on this cycle.
        vec(0, 0, 1, 5, 0, 0, 9, 1, 0);
        // Reset beats load and en on the same edge.
        vec(0, 1, 1, 2, 1, 1, 5, 0, 0);
        vec(0, 0, 1, 5, 0, 0, 0, 0, 0);
        vec(0, 0, 1, 2, 1, 1, 5, 0, 0);
        vec(0, 0, 1, 4, 0, 0, 2, 0, 0);
        // Hold at 4 for three cycles, then resume.
        vec(0, 0, 0, 0, 0, 1, 4, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 4, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 4, 0, 0);
        vec(0, 0, 0, 0, 1, 1, 4, 0, 0);
        // Reset mid-count, then first enabled edge gives 1.
        vec(0, 1, 0, 0, 1, 1, 5, 0, 0);
        vec(0, 0, 0, 0, 1, 1, 0, 0, 0);
        // Direction change on the same edge, then boundary loads 10 and 9.
        vec(0, 0, 0, 0, 1, 0, 1, 0, 0);
        vec(0, 0, 1, 10, 0, 0, 0, 0, 0);
        vec(0, 0, 1, 9, 1, 1, 9, 0, 0);
        // tc follows inputs even while reset is asserted; wrap stays 0.
        vec(0, 1, 0, 0, 1, 1, 9, 0, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // MODULUS=2 back-to-back wraps.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) vec(1, 0, 0, 0, 1, 1, i % 2, (i >= 2) && (i % 2 == 0), i % 2);

        // Random stream on both instances against the reference model.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        ma = 0; mb = 0; wa = 0; wb = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, e, u;
            int lv;
            exp_t x;
            r  = ($urandom_range(49) == 0);
            ld = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            u  = $urandom_range(1);
            lv = $urandom_range(15);
            drive(r, ld, lv, e, u);
            x.cyc = cyc; x.sel = 0; x.eq = 4'(ma); x.ew = wa; x.etc = mdl_tc(ma, 10, ld, e, u);
            sbq.push_back(x);
            x.sel = 1; x.eq = 4'(mb); x.ew = wb; x.etc = mdl_tc(mb, 2, ld, e, u);
            sbq.push_back(x);
            wa = !r && mdl_tc(ma, 10, ld, e, u);
            wb = !r && mdl_tc(mb, 2, ld, e, u);
            ma = mdl_next(ma, 10, r, ld, lv, e, u);
            mb = mdl_next(mb, 2, r, ld, lv % 4, e, u);
        end

        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expected entries never compared, required 0", sbq.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
